// File: rtl/fast_avg_seq.sv
// Fast-averaging code sequencer: NCH phase-staggered channels stepping through 2^NBITS codes,
// each held a programmable number of clocks. Define FAST_AVG_SEQ_WRAP_STB_EN to add wrap_stb.
module fast_avg_seq #(
    parameter int unsigned NBITS = 4,
    parameter int unsigned CNTW  = 32,
    parameter int unsigned NCH   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  on,
    input  logic [CNTW-1:0]       cnt_max,
    input  logic                  mode,
    output logic [NCH*NBITS-1:0]  out,
    output logic                  step_stb
`ifdef FAST_AVG_SEQ_WRAP_STB_EN
    ,
    output logic                  wrap_stb
`endif
);

    localparam int unsigned L      = 1 << NBITS;
    localparam int unsigned Offset = L / NCH;
    localparam logic [NBITS-1:0] LastStep = NBITS'(L - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               r_state, w_state_d;
    logic [CNTW-1:0]      r_cnta, w_cnta_d;
    logic [NBITS-1:0]     r_step, w_step_d;
    logic [CNTW-1:0]      r_hold_s, w_hold_d;
    logic                 r_mode_s, w_mode_d;
    logic [NCH*NBITS-1:0] r_out, w_out_d;
    logic                 r_step_stb, w_step_stb_d;

    logic [CNTW-1:0]      w_hold_ld;
    logic                 w_last;
    logic                 w_wrap;
    logic [NBITS-1:0]     w_step_inc;
    logic                 w_mode_next;

    function automatic logic [NBITS-1:0] f_seq(input logic [NBITS-1:0] k, input logic m);
        logic [NBITS-1:0] rev;
        for (int i = 0; i < NBITS; i++) begin
            rev[i] = k[NBITS-1-i];
        end
        return m ? k : rev;
    endfunction

    // Channel c runs Offset steps ahead of channel 0 on the shared step counter.
    function automatic logic [NCH*NBITS-1:0] f_codes(input logic [NBITS-1:0] s, input logic m);
        logic [NCH*NBITS-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            v[c*NBITS +: NBITS] = f_seq(s + NBITS'(c * Offset), m);
        end
        return v;
    endfunction

    assign w_hold_ld   = (cnt_max == '0) ? CNTW'(1) : cnt_max;
    assign w_last      = (r_cnta == r_hold_s - CNTW'(1));
    assign w_wrap      = w_last && (r_step == LastStep);
    assign w_step_inc  = r_step + NBITS'(1);
    // New mode must already govern the code emitted on the wrap edge.
    assign w_mode_next = w_wrap ? mode : r_mode_s;

    always_comb begin
        w_state_d    = r_state;
        w_cnta_d     = r_cnta;
        w_step_d     = r_step;
        w_hold_d     = r_hold_s;
        w_mode_d     = r_mode_s;
        w_out_d      = r_out;
        w_step_stb_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (on) begin
                    w_state_d = StRun;
                    w_cnta_d  = '0;
                    w_step_d  = '0;
                    w_hold_d  = w_hold_ld;
                    w_mode_d  = mode;
                    w_out_d   = f_codes('0, mode);
                end
            end
            StRun: begin
                if (!on) begin
                    w_state_d = StIdle;
                    w_cnta_d  = '0;
                    w_step_d  = '0;
                    w_out_d   = '0;
                end else if (w_last) begin
                    w_cnta_d     = '0;
                    w_step_d     = w_step_inc;
                    w_step_stb_d = 1'b1;
                    w_out_d      = f_codes(w_step_inc, w_mode_next);
                    if (w_wrap) begin
                        w_hold_d = w_hold_ld;
                        w_mode_d = mode;
                    end
                end else begin
                    w_cnta_d = r_cnta + CNTW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnta     <= '0;
            r_step     <= '0;
            r_hold_s   <= '0;
            r_mode_s   <= 1'b0;
            r_out      <= '0;
            r_step_stb <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnta     <= w_cnta_d;
            r_step     <= w_step_d;
            r_hold_s   <= w_hold_d;
            r_mode_s   <= w_mode_d;
            r_out      <= w_out_d;
            r_step_stb <= w_step_stb_d;
        end
    end

    assign out      = r_out;
    assign step_stb = r_step_stb;

`ifdef FAST_AVG_SEQ_WRAP_STB_EN
    logic r_wrap_stb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrap_stb <= 1'b0;
        end else begin
            r_wrap_stb <= (r_state == StRun) && on && w_wrap;
        end
    end

    assign wrap_stb = r_wrap_stb;
`endif

endmodule

// File: tb/tb_fast_avg_seq.sv
// Bench for fast_avg_seq (NBITS=4, CNTW=8, NCH=2): cycle model plus directed literal checks.
module tb_fast_avg_seq;

    localparam int NB = 4;
    localparam int CW = 8;
    localparam int NC = 2;
    localparam int L  = 16;

    logic          clk;
    logic          rst_n;
    logic          on;
    logic [CW-1:0] cnt_max;
    logic          mode;
    logic [7:0]    dut_out;
    logic          step_stb;
`ifdef FAST_AVG_SEQ_WRAP_STB_EN
    logic          wrap_stb;
`endif

    fast_avg_seq #(.NBITS(NB), .CNTW(CW), .NCH(NC)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .on       (on),
        .cnt_max  (cnt_max),
        .mode     (mode),
        .out      (dut_out),
        .step_stb (step_stb)
`ifdef FAST_AVG_SEQ_WRAP_STB_EN
        ,
        .wrap_stb (wrap_stb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int seq(input int k, input int md);
        int kk;
        int r;
        kk = k % L;
        r = 0;
        for (int b = 0; b < NB; b++) begin
            if (((kk >> b) & 1) != 0) r += 1 << (NB - 1 - b);
        end
        return (md != 0) ? kk : r;
    endfunction

    // Model: step index advances once every 'hold' clocks of running time.
    int         m_run = 0;
    int         m_step = 0;
    int         m_cnt = 0;
    int         m_hold = 1;
    int         m_mode = 0;
    logic [7:0] m_out = '0;
    logic       m_stb = 1'b0;
    logic       m_wrap = 1'b0;

    always @(posedge clk) begin
        m_stb  = 1'b0;
        m_wrap = 1'b0;
        if (!rst_n) begin
            m_run  = 0;
            m_step = 0;
            m_cnt  = 0;
        end else if (m_run == 0) begin
            if (on) begin
                m_run  = 1;
                m_hold = (cnt_max == 0) ? 1 : int'(cnt_max);
                m_mode = int'(mode);
                m_step = 0;
                m_cnt  = 0;
            end
        end else if (!on) begin
            m_run  = 0;
            m_step = 0;
            m_cnt  = 0;
        end else begin
            m_cnt++;
            if (m_cnt >= m_hold) begin
                m_cnt  = 0;
                m_step = (m_step + 1) % L;
                m_stb  = 1'b1;
                if (m_step == 0) begin
                    m_wrap = 1'b1;
                    m_hold = (cnt_max == 0) ? 1 : int'(cnt_max);
                    m_mode = int'(mode);
                end
            end
        end
        m_out = (m_run != 0) ? {4'(seq(m_step + L / NC, m_mode)), 4'(seq(m_step, m_mode))} : 8'h0;
        #1;
        chk("model_out", 32'(dut_out), 32'(m_out));
        chk("model_step_stb", 32'(step_stb), 32'(m_stb));
`ifdef FAST_AVG_SEQ_WRAP_STB_EN
        chk("model_wrap_stb", 32'(wrap_stb), 32'(m_wrap));
`endif
    end

    logic [3:0] lit0 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [3:0] lit1 [16] = '{1, 9, 5, 13, 3, 11, 7, 15, 0, 8, 4, 12, 2, 10, 6, 14};

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; on = 1'b0; cnt_max = 8'd1; mode = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_out", 32'(dut_out), 0);
        chk("reset_stb", 32'(step_stb), 0);

        // Bit-reversed order, hold 1, two staggered channels
        on = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            cyc();
            chk("rev_ch0", 32'(dut_out[3:0]), 32'(lit0[i % 16]));
            chk("rev_ch1", 32'(dut_out[7:4]), 32'(lit1[i % 16]));
            if (i > 0) chk("rev_stb", 32'(step_stb), 1);
        end
        on = 1'b0;
        cyc();
        chk("idle_out", 32'(dut_out), 0);

        // Linear ramp, hold 3
        mode = 1'b1; cnt_max = 8'd3; on = 1'b1;
        for (int i = 0; i <= 48; i++) begin
            cyc();
            chk("ramp_ch0", 32'(dut_out[3:0]), 32'((i / 3) % 16));
            chk("ramp_stb", 32'(step_stb), 32'((i > 0) && (i % 3 == 0)));
        end
        on = 1'b0;
        cyc();

        // Hold 2, cnt_max changed to 5 mid-period: applies only from the next wrap
        mode = 1'b0; cnt_max = 8'd2; on = 1'b1;
        for (int i = 0; i <= 69; i++) begin
            cyc();
            if (i == 31 || i == 63) chk("hold2_last", 32'(dut_out[3:0]), 15);
            if (i == 32 || i == 68) chk("hold_wrap0", 32'(dut_out[3:0]), 0);
            if (i == 41) chk("hold2_kept", 32'(dut_out[3:0]), 2);
            if (i == 45) chk("hold2_kept6", 32'(dut_out[3:0]), 6);
            if (i == 69) chk("hold5_step1", 32'(dut_out[3:0]), 8);
`ifdef FAST_AVG_SEQ_WRAP_STB_EN
            chk("wrap_stb", 32'(wrap_stb), 32'(i == 32 || i == 64));
`endif
            if (i == 40) cnt_max = 8'd5;
        end
        on = 1'b0;
        cyc();

        // cnt_max=0 acts as hold 1; drop on at step 6, then reset at step 6
        cnt_max = 8'd0; on = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            cyc();
            chk("zero_ch0", 32'(dut_out[3:0]), 32'(lit0[i]));
            if (i > 0) chk("zero_stb", 32'(step_stb), 1);
        end
        on = 1'b0;
        cyc();
        chk("drop_out", 32'(dut_out), 0);
        chk("drop_stb", 32'(step_stb), 0);
        on = 1'b1;
        cyc();
        chk("restart0", 32'(dut_out[3:0]), 0);
        cyc();
        chk("restart1", 32'(dut_out[3:0]), 8);
        repeat (5) cyc();
        chk("pre_rst_step6", 32'(dut_out[3:0]), 6);
        rst_n = 1'b0;
        cyc();
        chk("rst_out", 32'(dut_out), 0);
        chk("rst_stb", 32'(step_stb), 0);
        rst_n = 1'b1;
        cyc();
        chk("rst_restart0", 32'(dut_out[3:0]), 0);
        cyc();
        chk("rst_restart1", 32'(dut_out[3:0]), 8);
        on = 1'b0;
        cyc();

        // Maximum hold value
        cnt_max = 8'd255; on = 1'b1;
        for (int i = 0; i <= 255; i++) begin
            cyc();
            if (i == 254) chk("max_hold_kept", 32'(dut_out[3:0]), 0);
            if (i == 255) begin
                chk("max_hold_step", 32'(dut_out[3:0]), 8);
                chk("max_hold_stb", 32'(step_stb), 1);
            end
        end
        on = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
